dcache_wb: RTL and testbench

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_pkg.sv | 13 +
 rtl/dcache_wb_if.sv | 30 +++
 rtl/dcache_tag_array.sv | 47 ++++
 rtl/dcache_wb.sv | 118 +++++++++++
 tb/tb_dcache_wb.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    localparam int DEFAULT_NUM_LINES      = 16;
    localparam int DEFAULT_WORDS_PER_LINE = 4;

endpackage

// File: rtl/dcache_wb_if.sv
// Core-side request bus and backing-memory word bus of the data cache.
interface dcache_wb_if;

    logic        dmem_sel;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] dmem_data_wr;
    logic [31:0] dmem_data_rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // The cache itself.
    modport slave (
        input  dmem_sel, wr, mask, addr, dmem_data_wr, mem_rdata, mem_ack,
        output dmem_data_rd, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Whoever drives the core requests and answers the memory side.
    modport master (
        output dmem_sel, wr, mask, addr, dmem_data_wr, mem_rdata, mem_ack,
        input  dmem_data_rd, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_tag_array.sv
// Per-line tag, valid and dirty storage; valid/dirty clear on reset, tags do not.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEFAULT_NUM_LINES,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             rd_dirty,
    input  logic             set_dirty,
    input  logic             fill,
    input  logic [TAG_W-1:0] fill_tag
);

    logic [TAG_W-1:0]     tag_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_bits;
    logic [NUM_LINES-1:0] dirty_bits;

    // A completed refill makes the line valid and clean in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
        end else if (set_dirty) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx] <= fill_tag;
        end
    end

    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_bits[idx];
    assign rd_dirty = dirty_bits[idx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial
// backing-memory port; hits complete combinationally, misses stall the core.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = DEFAULT_NUM_LINES,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input logic        clk,
    input logic        rst,
    dcache_wb_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    state_t           state;
    logic [OFF_W-1:0] word_cnt;
    logic [31:0]      data_mem [NUM_LINES*WORDS_PER_LINE];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [TAG_W-1:0] line_tag;
    logic             line_valid;
    logic             line_dirty;
    logic             in_idle;
    logic             busy;
    logic             hit;
    logic             miss;
    logic             refill_wr;
    logic             unused_addr_lsbs;

    assign req_tag          = bus.addr[31 -: TAG_W];
    assign req_idx          = bus.addr[2+OFF_W +: IDX_W];
    assign req_off          = bus.addr[2 +: OFF_W];
    assign unused_addr_lsbs = ^bus.addr[1:0];

    // Reset forces every output quiet even while a transfer is still in flight.
    assign in_idle   = !rst && (state == IDLE);
    assign busy      = !rst && (state != IDLE);
    assign hit       = in_idle && bus.dmem_sel && line_valid && (line_tag == req_tag);
    assign miss      = in_idle && bus.dmem_sel && !hit;
    assign refill_wr = busy && (state == REFILL) && bus.mem_ack;

    dcache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .idx       (req_idx),
        .rd_tag    (line_tag),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .set_dirty (hit && bus.wr && (bus.mask != 4'b0000)),
        .fill      (refill_wr && (word_cnt == LAST_WORD)),
        .fill_tag  (req_tag)
    );

    assign bus.stall        = miss || busy;
    assign bus.mem_req      = busy;
    assign bus.mem_we       = busy && (state == WRITEBACK);
    assign bus.mem_addr     = busy ? {((state == WRITEBACK) ? line_tag : req_tag), req_idx, word_cnt, 2'b00}
                                   : 32'd0;
    assign bus.mem_wdata    = (busy && (state == WRITEBACK)) ? data_mem[{req_idx, word_cnt}] : 32'd0;
    assign bus.dmem_data_rd = (hit && !bus.wr) ? data_mem[{req_idx, req_off}] : 32'd0;

    // The word counter wraps naturally because WORDS_PER_LINE is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (miss) begin
                        state <= (line_valid && line_dirty) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (refill_wr) begin
            data_mem[{req_idx, word_cnt}] <= bus.mem_rdata;
        end else if (hit && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mask[b]) begin
                    data_mem[{req_idx, req_off}][8*b +: 8] <= bus.dmem_data_wr[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: a line-level cache/memory model predicts stalls,
// load data and the backing-memory transfer sequence, checked every cycle.
module tb_dcache_wb;

    localparam int NL         = 16;
    localparam int WPL        = 4;
    localparam int LINE_BYTES = WPL * 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic clk;
    logic rst;

    dcache_wb_if bus ();

    dcache_wb #(
        .NUM_LINES      (NL),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: architectural memory, backing memory, and line bookkeeping.
    logic [31:0]   arch_mem [int unsigned];
    logic [31:0]   back_mem [int unsigned];
    bit            mvalid [NL];
    bit            mdirty [NL];
    int unsigned   mtag   [NL];
    xfer_t         exp_q [$];
    int            exp_stall_left = 0;
    int            ack_delay      = 0;
    int            wait_cnt       = 0;
    bit            req_phase      = 1'b0;
    int            stall_seen     = 0;
    logic [31:0]   last_rd        = 32'd0;
    logic [31:0]   obs_addr  [$];
    logic [31:0]   obs_wdata [$];
    logic          obs_we    [$];

    function automatic logic [31:0] init_word(input int unsigned a);
        return a ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] back_word(input int unsigned a);
        return back_mem.exists(a) ? back_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] arch_word(input int unsigned a);
        return arch_mem.exists(a) ? arch_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] obsAddr(input int i);
        return (obs_addr.size() > i) ? obs_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] obsWdata(input int i);
        return (obs_wdata.size() > i) ? obs_wdata[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic obsWe(input int i);
        return (obs_we.size() > i) ? obs_we[i] : 1'bx;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NL; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        arch_mem.delete();
        foreach (back_mem[k]) arch_mem[k] = back_mem[k];
    endtask

    // Compare process plus backing-memory responder, both on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_stall", bus.stall, 1'b0);
            checkOutput("rst_mem_req", bus.mem_req, 1'b0);
            checkOutput("rst_mem_we", bus.mem_we, 1'b0);
            checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
            checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
            checkOutput("rst_rd", bus.dmem_data_rd, 32'd0);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'd0;
            wait_cnt      = 0;
        end else begin
            logic        exp_stall;
            logic        exp_req;
            logic [31:0] exp_rd;
            exp_stall = bus.dmem_sel && (exp_stall_left > 0);
            exp_rd    = (bus.dmem_sel && !exp_stall && !bus.wr) ? arch_word(bus.addr & ~32'd3) : 32'd0;
            checkOutput("stall", bus.stall, exp_stall);
            checkOutput("load_data", bus.dmem_data_rd, exp_rd);
            if (bus.dmem_sel && bus.stall) stall_seen++;
            if (bus.dmem_sel && !bus.stall) last_rd = bus.dmem_data_rd;
            if (bus.dmem_sel && exp_stall_left > 0) exp_stall_left--;

            exp_req = 1'b0;
            if (exp_q.size() > 0) begin
                if (req_phase) exp_req = 1'b1;
                else req_phase = 1'b1;
            end
            checkOutput("mem_req", bus.mem_req, exp_req);

            if (exp_req && bus.mem_req) begin
                checkOutput("mem_we", bus.mem_we, exp_q[0].we);
                checkOutput("mem_addr", bus.mem_addr, exp_q[0].addr);
                if (exp_q[0].we) checkOutput("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        back_mem[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = 32'd0;
                    end else begin
                        bus.mem_rdata = back_word(bus.mem_addr);
                    end
                    obs_addr.push_back(bus.mem_addr);
                    obs_wdata.push_back(bus.mem_wdata);
                    obs_we.push_back(bus.mem_we);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) req_phase = 1'b0;
                    wait_cnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                if (!bus.mem_req) begin
                    checkOutput("idle_mem_we", bus.mem_we, 1'b0);
                    checkOutput("idle_mem_addr", bus.mem_addr, 32'd0);
                end
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    // Predicts the miss handling for one access and returns the expected stall length.
    function automatic int predictAccess(input logic w, input logic [31:0] a, input logic [3:0] m, input int delay);
        int unsigned wa   = a & ~32'd3;
        int unsigned idx  = (wa / LINE_BYTES) % NL;
        int unsigned tag  = wa / (LINE_BYTES * NL);
        int unsigned base = wa & ~(LINE_BYTES - 1);
        int          n    = 0;
        if (!(mvalid[idx] && mtag[idx] == tag)) begin
            if (mvalid[idx] && mdirty[idx]) begin
                int unsigned vbase = (mtag[idx] * NL + idx) * LINE_BYTES;
                for (int k = 0; k < WPL; k++) begin
                    exp_q.push_back('{1'b1, vbase + 4*k, arch_word(vbase + 4*k)});
                    n++;
                end
            end
            for (int k = 0; k < WPL; k++) begin
                exp_q.push_back('{1'b0, base + 4*k, 32'd0});
                n++;
            end
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
            mdirty[idx] = 1'b0;
        end
        if (w && m != 4'b0000) mdirty[idx] = 1'b1;
        return (n == 0) ? 0 : 1 + n * (delay + 1);
    endfunction

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] m,
                                 input logic [31:0] d, input int delay);
        int          n;
        int unsigned wa;
        logic [31:0] merged;
        @(posedge clk);
        #1;
        obs_addr.delete();
        obs_wdata.delete();
        obs_we.delete();
        stall_seen       = 0;
        ack_delay        = delay;
        n                = predictAccess(w, a, m, delay);
        exp_stall_left   = n;
        bus.wr           = w;
        bus.addr         = a;
        bus.mask         = m;
        bus.dmem_data_wr = d;
        bus.dmem_sel     = 1'b1;
        repeat (n + 1) @(posedge clk);
        #1;
        bus.dmem_sel = 1'b0;
        bus.wr       = 1'b0;
        if (w) begin
            wa     = a & ~32'd3;
            merged = arch_word(wa);
            for (int b = 0; b < 4; b++) begin
                if (m[b]) merged[8*b +: 8] = d[8*b +: 8];
            end
            arch_mem[wa] = merged;
        end
        checkOutput("xfers_done", exp_q.size(), 0);
        exp_q.delete();
        req_phase      = 1'b0;
        exp_stall_left = 0;
    endtask

    // Issues a load, then pulls reset while the second refill word is on the bus.
    task automatic resetDuringRefill(input logic [31:0] a);
        int n;
        @(posedge clk);
        #1;
        obs_addr.delete();
        obs_wdata.delete();
        obs_we.delete();
        ack_delay      = 0;
        n              = predictAccess(1'b0, a, 4'b0000, 0);
        exp_stall_left = n;
        bus.wr         = 1'b0;
        bus.addr       = a;
        bus.mask       = 4'b0000;
        bus.dmem_sel   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst            = 1'b1;
        bus.dmem_sel   = 1'b0;
        exp_q.delete();
        exp_stall_left = 0;
        req_phase      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("words_before_reset", obs_addr.size(), 1);
        checkOutput("first_refill_addr", obsAddr(0), a & ~32'(LINE_BYTES - 1));
    endtask

    initial begin
        rst              = 1'b1;
        bus.dmem_sel     = 1'b0;
        bus.wr           = 1'b0;
        bus.mask         = 4'b0000;
        bus.addr         = 32'd0;
        bus.dmem_data_wr = 32'd0;
        back_mem[32'h40] = 32'hCAFE_0040;
        back_mem[32'h44] = 32'h1122_3344;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold load: clean refill of line 0x40.
        applyStimulus(1'b0, 32'h40, 4'b0000, 32'd0, 0);
        checkOutput("cold_stall", stall_seen, 5);
        checkOutput("cold_first_addr", obsAddr(0), 32'h40);
        checkOutput("cold_last_addr", obsAddr(3), 32'h4C);
        checkOutput("cold_data", last_rd, 32'hCAFE_0040);

        // Partial store hit, then read back the merged word.
        applyStimulus(1'b1, 32'h44, 4'b0011, 32'hDEAD_BEEF, 0);
        checkOutput("store_hit_stall", stall_seen, 0);
        applyStimulus(1'b0, 32'h44, 4'b0000, 32'd0, 0);
        checkOutput("merged_data", last_rd, 32'h1122_BEEF);

        // A mask-zero store must not dirty the line.
        applyStimulus(1'b0, 32'h80, 4'b0000, 32'd0, 0);
        applyStimulus(1'b1, 32'h80, 4'b0000, 32'hFFFF_FFFF, 0);
        applyStimulus(1'b0, 32'h180, 4'b0000, 32'd0, 0);
        checkOutput("mask0_clean_stall", stall_seen, 5);
        checkOutput("mask0_no_wb", obsWe(0), 1'b0);

        // Dirty line at index 0 evicted by a conflicting load.
        applyStimulus(1'b1, 32'h0, 4'b1111, 32'h1234_5678, 0);
        applyStimulus(1'b0, 32'h100, 4'b0000, 32'd0, 0);
        checkOutput("dirty_stall", stall_seen, 9);
        checkOutput("wb_addr0", obsAddr(0), 32'h0);
        checkOutput("wb_we0", obsWe(0), 1'b1);
        checkOutput("wb_data0", obsWdata(0), 32'h1234_5678);
        checkOutput("wb_then_refill", obsAddr(4), 32'h100);

        // Slow memory: ack after three wait cycles per word.
        applyStimulus(1'b0, 32'h140, 4'b0000, 32'd0, 3);
        checkOutput("slow_dirty_stall", stall_seen, 33);
        checkOutput("slow_wb_addr", obsAddr(0), 32'h40);
        checkOutput("slow_wb_data1", obsWdata(1), 32'h1122_BEEF);
        applyStimulus(1'b0, 32'h44, 4'b0000, 32'd0, 3);
        checkOutput("slow_clean_stall", stall_seen, 17);
        checkOutput("slow_reload", last_rd, 32'h1122_BEEF);

        // Store miss allocates, then merges.
        applyStimulus(1'b1, 32'h2C4, 4'b1100, 32'hAABB_CCDD, 0);
        checkOutput("store_miss_stall", stall_seen, 5);
        applyStimulus(1'b0, 32'h2C4, 4'b0000, 32'd0, 0);
        checkOutput("store_miss_data", last_rd, 32'hAABB_02C4);

        // Reset mid-refill abandons the line and discards dirty contents.
        resetDuringRefill(32'h50);
        applyStimulus(1'b0, 32'h50, 4'b0000, 32'd0, 0);
        checkOutput("post_reset_miss", stall_seen, 5);
        checkOutput("post_reset_data", last_rd, 32'h5EED_0050);
        applyStimulus(1'b0, 32'h2C4, 4'b0000, 32'd0, 0);
        checkOutput("lost_dirty_stall", stall_seen, 5);
        checkOutput("lost_dirty_data", last_rd, 32'h5EED_02C4);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
